// File: rtl/affine_mv_gen_seq.sv
// Sequential 4/6-parameter affine MV generator: one 1/16-pel MV per 4x4 sub-block, raster order.
// Build option MV_CLIP_EN: saturate MVs to OUT_W bits (default build wraps).
module affine_mv_gen_seq #(
    parameter int MV_W      = 16,
    parameter int OUT_W     = 16,
    parameter int COORD_W   = 8,
    parameter int LOG2_CU_W = 3,
    parameter int LOG2_CU_H = 3
) (
    input  logic                 CLK,
    input  logic                 RST_ASYNC_N,
    input  logic                 START,
    input  logic                 MODE_6PARAM,
    input  logic [COORD_W-1:0]   COORD_X,
    input  logic [COORD_W-1:0]   COORD_Y,
    input  logic [2*MV_W-1:0]    CPMV_0,
    input  logic [2*MV_W-1:0]    CPMV_1,
    input  logic [2*MV_W-1:0]    CPMV_2,
    output logic                 BUSY,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [OUT_W-5:0]     OUT_MV_X_INTEGER,
    output logic [3:0]           OUT_MV_X_FRAC,
    output logic [OUT_W-5:0]     OUT_MV_Y_INTEGER,
    output logic [3:0]           OUT_MV_Y_FRAC,
    output logic                 INTERP_X,
    output logic                 INTERP_Y,
    output logic [COORD_W-1:0]   OUT_POS_X,
    output logic [COORD_W-1:0]   OUT_POS_Y,
    output logic                 OUT_LAST,
    output logic                 DONE
);

    localparam int SX = 7 - LOG2_CU_W;
    localparam int SY = 7 - LOG2_CU_H;
    localparam int CW = LOG2_CU_W - 2;
    localparam int RW = LOG2_CU_H - 2;
    localparam int DW = MV_W + 5;
    localparam int AW = ((MV_W > OUT_W) ? MV_W : OUT_W) + 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FIN
    } state_t;

    state_t state, state_n;

    logic                      mode_q;
    logic [COORD_W-1:0]        cx_q, cy_q;
    logic signed [MV_W-1:0]    mv0h, mv0v, mv1h, mv1v, mv2h, mv2v;
    logic signed [DW-1:0]      da, db, dc, dd;
    logic signed [DW-1:0]      d1h, d1v, d2h, d2v;
    logic [CW-1:0]             col;
    logic [RW-1:0]             row;
    logic                      gen_done;

    logic [OUT_W-1:0]          mvx_q, mvy_q;
    logic [COORD_W-1:0]        posx_q, posy_q;
    logic                      valid_q, last_q;

    logic signed [AW-1:0]      xs, ys, acc_x, acc_y;
    logic                      sb_last, load_sb, xfer;

`ifdef MV_CLIP_EN
    localparam logic signed [AW-1:0] MV_MAX =
        {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [AW-1:0] MV_MIN =
        {{(AW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

    // Drop the 7 rounding bits and reduce to OUT_W.
    function automatic logic [OUT_W-1:0] reduce(input logic signed [AW-1:0] v);
`ifdef MV_CLIP_EN
        logic signed [AW-1:0] sh;
        sh = v >>> 7;
        if (sh > MV_MAX) return MV_MAX[OUT_W-1:0];
        if (sh < MV_MIN) return MV_MIN[OUT_W-1:0];
        return sh[OUT_W-1:0];
`else
        return OUT_W'(v >>> 7);
`endif
    endfunction

    always_comb begin
        d1h = DW'(mv1h) - DW'(mv0h);
        d1v = DW'(mv1v) - DW'(mv0v);
        d2h = DW'(mv2h) - DW'(mv0h);
        d2v = DW'(mv2v) - DW'(mv0v);
    end

    always_comb begin
        xs    = AW'({1'b0, col, 2'b10});
        ys    = AW'({1'b0, row, 2'b10});
        acc_x = (AW'(mv0h) <<< 7) + AW'(da) * xs + AW'(dc) * ys + AW'(64);
        acc_y = (AW'(mv0v) <<< 7) + AW'(db) * xs + AW'(dd) * ys + AW'(64);
    end

    always_comb begin
        sb_last = (&col) && (&row);
        xfer    = valid_q && OUT_READY;
        load_sb = (state == S_RUN) && !gen_done && (!valid_q || OUT_READY);
    end

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) state <= S_IDLE;
        else              state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (START) state_n = S_LOAD;
            S_LOAD: state_n = S_RUN;
            S_RUN:  if (xfer && last_q) state_n = S_FIN;
            S_FIN:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            mode_q   <= 1'b0;
            cx_q     <= '0;
            cy_q     <= '0;
            mv0h     <= '0;
            mv0v     <= '0;
            mv1h     <= '0;
            mv1v     <= '0;
            mv2h     <= '0;
            mv2v     <= '0;
            da       <= '0;
            db       <= '0;
            dc       <= '0;
            dd       <= '0;
            col      <= '0;
            row      <= '0;
            gen_done <= 1'b0;
            mvx_q    <= '0;
            mvy_q    <= '0;
            posx_q   <= '0;
            posy_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            if (state == S_IDLE && START) begin
                mode_q <= MODE_6PARAM;
                cx_q   <= COORD_X;
                cy_q   <= COORD_Y;
                mv0h   <= CPMV_0[2*MV_W-1:MV_W];
                mv0v   <= CPMV_0[MV_W-1:0];
                mv1h   <= CPMV_1[2*MV_W-1:MV_W];
                mv1v   <= CPMV_1[MV_W-1:0];
                mv2h   <= CPMV_2[2*MV_W-1:MV_W];
                mv2v   <= CPMV_2[MV_W-1:0];
            end

            if (state == S_LOAD) begin
                da       <= d1h <<< SX;
                db       <= d1v <<< SX;
                dc       <= mode_q ? (d2h <<< SY) : -(d1v <<< SX);
                dd       <= mode_q ? (d2v <<< SY) : (d1h <<< SX);
                col      <= '0;
                row      <= '0;
                gen_done <= 1'b0;
            end

            if (load_sb) begin
                valid_q <= 1'b1;
                last_q  <= sb_last;
                mvx_q   <= reduce(acc_x);
                mvy_q   <= reduce(acc_y);
                posx_q  <= cx_q + COORD_W'({col, 2'b00});
                posy_q  <= cy_q + COORD_W'({row, 2'b00});
                if (&col) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (sb_last) gen_done <= 1'b1;
            end else if (xfer) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign BUSY             = (state != S_IDLE);
    assign DONE             = (state == S_FIN);
    assign OUT_VALID        = valid_q;
    assign OUT_LAST         = last_q;
    assign OUT_MV_X_INTEGER = mvx_q[OUT_W-1:4];
    assign OUT_MV_X_FRAC    = mvx_q[3:0];
    assign OUT_MV_Y_INTEGER = mvy_q[OUT_W-1:4];
    assign OUT_MV_Y_FRAC    = mvy_q[3:0];
    assign INTERP_X         = |mvx_q[3:0];
    assign INTERP_Y         = |mvy_q[3:0];
    assign OUT_POS_X        = posx_q;
    assign OUT_POS_Y        = posy_q;

endmodule
